// File: rtl/griffin_io_pkg.sv
// Shared types and element-index mapping for the griffin streaming front/back end.
// Element k lives at word k % STATE_SIZE of lane k / STATE_SIZE.
package griffin_io_pkg;

  localparam int unsigned N_BITS      = 254;
  localparam int unsigned STATE_SIZE  = 3;
  localparam int unsigned NUM_LANES   = 13;
  localparam int unsigned TOTAL_ELEMS = STATE_SIZE * NUM_LANES;

  localparam int unsigned IDX_W  = $clog2(TOTAL_ELEMS);
  localparam int unsigned LANE_W = $clog2(NUM_LANES);
  localparam int unsigned WORD_W = $clog2(STATE_SIZE);

  typedef logic [N_BITS-1:0] elem_t;
  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [STATE_SIZE-1:0][NUM_LANES-1:0][N_BITS-1:0] state_arr_t;

  typedef enum logic [1:0] {
    LOAD,
    RUN,
    DRAIN
  } state_t;

  localparam idx_t LAST_IDX = idx_t'(TOTAL_ELEMS - 1);

  function automatic logic [LANE_W-1:0] lane_of(input idx_t k);
    return LANE_W'(k / idx_t'(STATE_SIZE));
  endfunction

  function automatic logic [WORD_W-1:0] word_of(input idx_t k);
    return WORD_W'(k % idx_t'(STATE_SIZE));
  endfunction

endpackage

// File: rtl/griffin_stream_io.sv
// Serial valid/ready wrapper around the parallel griffin core: packs 39 input elements,
// runs the core until a fresh done edge, then streams the 39 result elements back out.
module griffin_stream_io
  import griffin_io_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             in_valid,
  output logic                                             in_ready,
  input  logic [N_BITS-1:0]                                in_data,
  input  logic                                             in_last,
  output logic                                             out_valid,
  input  logic                                             out_ready,
  output logic [N_BITS-1:0]                                out_data,
  output logic                                             out_last,
  output logic                                             core_enable,
  output logic [STATE_SIZE-1:0][NUM_LANES-1:0][N_BITS-1:0] core_inState,
  input  logic [STATE_SIZE-1:0][NUM_LANES-1:0][N_BITS-1:0] core_outState,
  input  logic                                             core_done,
  output logic [CNT_W-1:0]                                 run_cycles,
  output logic                                             busy
);

  state_t           state_q;
  idx_t             k_q;
  idx_t             k_inc;
  state_arr_t       inbuf_q;
  state_arr_t       outbuf_q;
  logic             done_q;
  logic [CNT_W-1:0] cnt_q;
  logic             capture;

  assign core_inState = inbuf_q;
  assign k_inc        = k_q + idx_t'(1);

  // Only a fresh rising edge of done counts, so a level left over from the last run is ignored.
  assign capture = (state_q == RUN) && core_done && !done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= LOAD;
      k_q         <= '0;
      inbuf_q     <= '0;
      outbuf_q    <= '0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
      run_cycles  <= '0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      core_enable <= 1'b0;
      busy        <= 1'b0;
    end else begin
      done_q <= core_done;
      unique case (state_q)
        LOAD: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            inbuf_q[word_of(k_q)][lane_of(k_q)] <= in_data;
            if ((k_q == LAST_IDX) || in_last) begin
              state_q  <= RUN;
              k_q      <= '0;
              cnt_q    <= '0;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end else begin
              k_q <= k_inc;
            end
          end
        end

        RUN: begin
          if (capture) begin
            outbuf_q    <= core_outState;
            run_cycles  <= cnt_q;
            core_enable <= 1'b0;
            state_q     <= DRAIN;
            k_q         <= '0;
            out_valid   <= 1'b1;
            out_data    <= core_outState[0][0];
            out_last    <= 1'b0;
          end else begin
            core_enable <= 1'b1;
            if (cnt_q != '1) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end

        DRAIN: begin
          if (out_ready) begin
            if (k_q == LAST_IDX) begin
              // Clear the input side here so the next load starts from an all-zero state.
              state_q   <= LOAD;
              k_q       <= '0;
              inbuf_q   <= '0;
              out_valid <= 1'b0;
              out_data  <= '0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
            end else begin
              k_q      <= k_inc;
              out_data <= outbuf_q[word_of(k_inc)][lane_of(k_inc)];
              out_last <= (k_inc == LAST_IDX);
            end
          end
        end

        default: begin
          state_q <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_griffin_stream_io.sv
// Directed bench for griffin_stream_io with a behavioural griffin core stub (out = in + 100).
module tb_griffin_stream_io;
  import griffin_io_pkg::*;

  localparam int unsigned CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  elem_t            in_data = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  elem_t            out_data;
  logic             out_last;
  logic             core_enable;
  state_arr_t       core_inState;
  state_arr_t       core_outState;
  logic             core_done;
  logic [CNT_W-1:0] run_cycles;
  logic             busy;

  logic stub_done = 1'b0;
  logic man_done  = 1'b0;
  logic auto_done = 1'b1;
  int   en_cnt    = 0;

  int n_checks = 0;
  int n_pass   = 0;

  elem_t stim    [TOTAL_ELEMS];
  elem_t exp_out [TOTAL_ELEMS];

  always #5 clk = ~clk;

  griffin_stream_io #(
    .CNT_W(CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .core_enable  (core_enable),
    .core_inState (core_inState),
    .core_outState(core_outState),
    .core_done    (core_done),
    .run_cycles   (run_cycles),
    .busy         (busy)
  );

  // Core stub: done rises 20 enabled cycles after enable goes high.
  always @(posedge clk) begin
    if (!core_enable) begin
      en_cnt    <= 0;
      stub_done <= 1'b0;
    end else begin
      en_cnt <= en_cnt + 1;
      if (en_cnt == 19) stub_done <= 1'b1;
    end
  end

  assign core_done = auto_done ? stub_done : man_done;

  always_comb begin
    core_outState = '0;
    for (int j = 0; j < STATE_SIZE; j++) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        core_outState[j][i] = core_inState[j][i] + elem_t'(100);
      end
    end
  end

  task automatic check(input string tag, input elem_t got, input elem_t exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input elem_t d, input logic last);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) check("in_ready_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic load(input int n, input bit use_last);
    for (int k = 0; k < n; k++) send(stim[k], use_last && (k == n - 1));
    for (int k = 0; k < TOTAL_ELEMS; k++) begin
      exp_out[k] = ((k < n) ? stim[k] : '0) + elem_t'(100);
    end
  endtask

  task automatic drain(input int n_hs, input bit stall);
    int    got = 0;
    int    guard = 0;
    int    phase = 0;
    elem_t held;
    logic  stalled;
    while (got < n_hs && guard < 2000) begin
      out_ready = stall ? (phase % 3 == 0) : 1'b1;
      stalled   = out_valid && !out_ready;
      held      = out_data;
      if (out_valid && out_ready) begin
        check($sformatf("out_data[%0d]", got), out_data, exp_out[got]);
        check($sformatf("out_last[%0d]", got), out_last, (got == TOTAL_ELEMS - 1));
        got++;
      end
      tick();
      phase++;
      guard++;
      if (stalled) check("stall_hold", out_data, held);
    end
    out_ready = 1'b0;
    check("handshake_count", got, n_hs);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_enable", core_enable, 0);
    check("rst_run_cycles", run_cycles, 0);
    check("rst_out_data", out_data, 0);
    check("rst_inState_zero", core_inState == '0, 1);
    reset = 1'b0;
    tick();
    check("post_rst_in_ready", in_ready, 1);

    // 1: full load then drain
    for (int k = 0; k < TOTAL_ELEMS; k++) stim[k] = elem_t'(k + 1);
    load(TOTAL_ELEMS, 1'b1);
    check("t1_busy", busy, 1);
    check("t1_in_ready_low", in_ready, 0);
    check("t1_enable_entry", core_enable, 0);
    for (int j = 0; j < STATE_SIZE; j++) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        check($sformatf("t1_inState[%0d][%0d]", j, i), core_inState[j][i],
              elem_t'(3 * i + j + 1));
      end
    end
    tick();
    check("t1_enable_on", core_enable, 1);
    drain(TOTAL_ELEMS, 1'b0);
    check("t1_run_cycles", run_cycles, 21);
    check("t1_busy_done", busy, 0);
    check("t1_valid_done", out_valid, 0);
    check("t1_in_ready_back", in_ready, 1);
    check("t1_enable_off", core_enable, 0);

    // 2: output backpressure
    for (int k = 0; k < TOTAL_ELEMS; k++) stim[k] = elem_t'(7 * k + 3);
    load(TOTAL_ELEMS, 1'b1);
    drain(TOTAL_ELEMS, 1'b1);
    check("t2_run_cycles", run_cycles, 21);

    // 3: early in_last
    for (int k = 0; k < 5; k++) stim[k] = elem_t'(7 + k);
    load(5, 1'b1);
    check("t3_busy", busy, 1);
    check("t3_in_ready_low", in_ready, 0);
    check("t3_slot_0_0", core_inState[0][0], 7);
    check("t3_slot_1_1", core_inState[1][1], 11);
    check("t3_slot_2_1", core_inState[2][1], 0);
    for (int j = 0; j < STATE_SIZE; j++) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        check($sformatf("t3_inState[%0d][%0d]", j, i), core_inState[j][i],
              (3 * i + j < 5) ? elem_t'(3 * i + j + 7) : '0);
      end
    end
    drain(TOTAL_ELEMS, 1'b0);

    // 4: stale done held into RUN
    auto_done = 1'b0;
    man_done  = 1'b1;
    tick();
    tick();
    stim[0] = elem_t'(5);
    load(1, 1'b1);
    repeat (3) tick();
    man_done = 1'b0;
    repeat (10) tick();
    check("t4_no_stale_capture", out_valid, 0);
    man_done = 1'b1;
    tick();
    check("t4_capture_on_rise", out_valid, 1);
    check("t4_run_cycles", run_cycles, 13);
    drain(TOTAL_ELEMS, 1'b0);
    man_done  = 1'b0;
    auto_done = 1'b1;
    tick();

    // 5: reset mid-drain
    for (int k = 0; k < TOTAL_ELEMS; k++) stim[k] = elem_t'(k + 200);
    load(TOTAL_ELEMS, 1'b1);
    drain(10, 1'b0);
    reset = 1'b1;
    #1;
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_enable", core_enable, 0);
    check("t5_rst_busy", busy, 0);
    #2;
    reset = 1'b0;
    tick();
    check("t5_in_ready", in_ready, 1);
    check("t5_inState_zero", core_inState == '0, 1);
    check("t5_run_cycles_clr", run_cycles, 0);
    for (int k = 0; k < TOTAL_ELEMS; k++) stim[k] = elem_t'(k + 300);
    load(TOTAL_ELEMS, 1'b1);
    drain(TOTAL_ELEMS, 1'b0);

    // 6: back-to-back runs, the second short so any residue would show
    for (int k = 0; k < TOTAL_ELEMS; k++) stim[k] = elem_t'(k * k + 1);
    load(TOTAL_ELEMS, 1'b0);
    drain(TOTAL_ELEMS, 1'b0);
    for (int k = 0; k < 3; k++) stim[k] = elem_t'(1000 - k);
    load(3, 1'b1);
    drain(TOTAL_ELEMS, 1'b0);
    check("t6_busy_done", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/griffin_stream_io.md
Name: griffin_stream_io

Overview:
Streaming front/back end for the griffin permutation core. It accepts 39 field elements serially over a valid/ready input stream and packs them into the core's parallel inState[3][13] array. It then drives enable, waits for done, captures outState, and streams the 39 result elements out over a valid/ready output stream. It sits between the system bus or DMA and the parallel-port griffin core.

Parameters:
N_BITS, 254, field element width
STATE_SIZE, 3, words per lane (first array index)
NUM_LANES, 13, lanes (second array index)
CNT_W, 32, width of run_cycles counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  input element valid
in_ready  out  1  input element accepted when in_valid && in_ready
in_data  in  N_BITS  input field element, already reduced mod p
in_last  in  1  marks final input element (early-terminate)
out_valid  out  1  output element valid
out_ready  in  1  downstream accept
out_data  out  N_BITS  output field element
out_last  out  1  high with element 38
core_enable  out  1  to griffin enable
core_inState  out  N_BITS x [STATE_SIZE][NUM_LANES]  to griffin inState
core_outState  in  N_BITS x [STATE_SIZE][NUM_LANES]  from griffin outState
core_done  in  1  from griffin done
run_cycles  out  CNT_W  cycles spent in RUN for the last completed permutation
busy  out  1  high in RUN or DRAIN

Behaviour:
- Element index k (0..38) maps to lane i=k/STATE_SIZE, word j=k%STATE_SIZE; stream order is k ascending, i.e. inState[j][i] = element 3i+j. The same map applies on output.
- FSM states: LOAD, RUN, DRAIN. Reset state is LOAD.
- Reset (async, any state): go to LOAD; element counter=0; in/out buffers zeroed; core_enable=0, out_valid=0, out_last=0, out_data=0, run_cycles=0, busy=0. in_ready=1 from the first clock after reset deasserts.
- LOAD: in_ready=1. Each handshake writes in_data to slot k and increments k. On the handshake at k=38, or a handshake with in_last=1 at any k, go to RUN and clear k. Unwritten slots stay zero (buffer is cleared on every entry to LOAD).
- core_inState is driven continuously from the input buffer.
- RUN: in_ready=0; core_enable=1 registered, asserted the cycle after entry; the cycle counter clears on entry and increments each RUN cycle.
- Capture fires on a rising edge of core_done (core_done=1 and its registered previous value=0) sampled in RUN. A done level held over from the previous run is ignored until it drops. On capture: latch core_outState into the output buffer, latch the counter into run_cycles, core_enable=0 next cycle, go to DRAIN.
- DRAIN: out_valid=1, out_data=outbuf[k], out_last=(k==38). On handshake k increments. out_data and out_last stay stable while out_valid && !out_ready.
- After the handshake at k=38: go to LOAD, zero the input buffer, k=0. in_ready=1 the next cycle; there is no overlap of LOAD with DRAIN.
- The cycle counter saturates at all-ones and does not wrap.
- in_valid asserted outside LOAD is ignored. out_ready outside DRAIN is ignored.

Decomposition:
- Package griffin_io_pkg holds:
  - N_BITS, STATE_SIZE, NUM_LANES
  - TOTAL_ELEMS=STATE_SIZE*NUM_LANES
  - elem_t (logic [N_BITS-1:0])
  - state_t enum {LOAD, RUN, DRAIN}
  - functions lane_of(k) and word_of(k)
- No sub-module: the FSM, counters and two buffers live in one module.
- Bench uses a behavioural griffin stub.

Test Plan:
1. Full load then drain:
   - Stimulus: stream elements 1..39 with in_last on the 39th; stub asserts done 20 cycles after enable rises and returns in+100.
   - Required: core_inState[j][i]=3i+j+1; out stream 101..139; out_last only on 139; run_cycles=21; busy low afterwards.
2. Output backpressure:
   - Stimulus: out_ready toggles 1,0,0,1... during DRAIN.
   - Required: out_data holds each value across the stall cycles; exactly 39 handshakes in order; no duplicates or drops.
3. Early in_last:
   - Stimulus: 5 elements (values 7,8,9,10,11), in_last on the 5th.
   - Required: RUN entered next cycle; core_inState[0][0]=7, [1][1]=11, [2][1]=0, all other slots 0.
4. Stale done:
   - Stimulus: stub holds core_done=1 when RUN is entered, drops it after 3 cycles, re-raises it 10 cycles later.
   - Required: capture occurs only on the re-rise; out_valid first asserts on the cycle after it.
5. Reset mid-DRAIN:
   - Stimulus: assert reset after 10 output handshakes.
   - Required: out_valid=0, core_enable=0, busy=0 asynchronously; after release, in_ready=1 and core_inState all zero; a fresh 39-element run completes correctly.
6. Back-to-back runs:
   - Stimulus: two consecutive loads with different vectors.
   - Required: the second run's outputs depend only on the second load; no residue from the first.
